// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// one iteration per clock. Feeds the 4-digit multiplexed 7-segment
// display driver with registered digits that only change on completion.
module bin2bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       thou,
  output logic [3:0]       hund,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] binreg;
  logic [15:0]      scratch;
  logic             ovf_pend;

  logic             accept;
  logic             last;
  logic             bin_big;
  logic [11:0]      adj_low;
  logic [2:0]       adj_top;
  logic [15:0]      scratch_nxt;
  logic [WIDTH-1:0] binreg_nxt;

  // Overflow detection on the raw input; zero-extend so narrow WIDTH compares cleanly
  always_comb begin
    bin_big = ({{(16 - WIDTH){1'b0}}, bin} > 16'd9999);
  end

  // Add-3 adjust of each BCD nibble followed by the one-bit left shift.
  // Only the low three bits of the adjusted top nibble survive the shift,
  // so that nibble is adjusted modulo 8 and its carry-out is dropped.
  always_comb begin
    adj_low = scratch[11:0];
    for (int i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj_low[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    adj_top     = scratch[14:12] + ((scratch[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    scratch_nxt = {adj_top, adj_low, binreg[WIDTH-1]};
    binreg_nxt  = {binreg[WIDTH-2:0], 1'b0};
  end

  // State register; reset wins over any pending start
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus busy/done, accept and last-iteration strobes
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Scratch datapath: load on accept, iterate while shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      binreg   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else if (accept) begin
      binreg   <= bin;
      scratch  <= '0;
      cnt      <= CW'(WIDTH);
      ovf_pend <= bin_big;
    end else if (state == SHIFT) begin
      binreg   <= binreg_nxt;
      scratch  <= scratch_nxt;
      cnt      <= cnt - CW'(1);
    end
  end

  // Display-facing outputs only move on the completion edge, saturating on overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf  <= 1'b0;
      thou <= 4'd0;
      hund <= 4'd0;
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (last) begin
      ovf <= ovf_pend;
      if (ovf_pend) begin
        thou <= 4'd9;
        hund <= 4'd9;
        tens <= 4'd9;
        ones <= 4'd9;
      end else begin
        thou <= scratch_nxt[15:12];
        hund <= scratch_nxt[11:8];
        tens <= scratch_nxt[7:4];
        ones <= scratch_nxt[3:0];
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq with an expected-result queue.
module tb_bin2bcd_seq;

  localparam int WIDTH = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       thou;
  logic [3:0]       hund;
  logic [3:0]       tens;
  logic [3:0]       ones;

  int          tests = 0;
  int          fails = 0;
  logic [16:0] sbq[$];
  logic [16:0] lastExp;

  bin2bcd_seq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .thou (thou),
    .hund (hund),
    .tens (tens),
    .ones (ones)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] expOf(input int v);
    logic [16:0] r;
    if (v > 9999) begin
      r = {1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
    end else begin
      r = {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int v);
    bin   = WIDTH'(v);
    start = 1'b1;
    sbq.push_back(expOf(v));
    tick();
    start = 1'b0;
    bin   = WIDTH'($urandom);
  endtask

  task automatic waitDone(input string tag, input int expWait, input int already);
    int          waited;
    int          busyN;
    logic        held;
    logic [16:0] exp;
    waited = already;
    busyN  = 0;
    held   = 1'b1;
    while (done !== 1'b1 && waited < 40) begin
      if (busy === 1'b1) busyN++;
      if ({ovf, thou, hund, tens, ones} !== lastExp) held = 1'b0;
      tick();
      waited++;
    end
    checkOutput({tag, " latency"}, waited - already, expWait);
    checkOutput({tag, " busy cycles"}, busyN, expWait);
    checkOutput({tag, " digits held"}, {31'd0, held}, 32'd1);
    if (sbq.size() > 0) begin
      exp = sbq.pop_front();
      checkOutput({tag, " digits"}, {15'd0, ovf, thou, hund, tens, ones}, {15'd0, exp});
      lastExp = exp;
    end else begin
      checkOutput({tag, " scoreboard"}, 32'd0, 32'd1);
    end
  endtask

  task automatic finishIdle(input string tag);
    tick();
    checkOutput({tag, " done width"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic runConv(input string tag, input int v);
    applyStimulus(v);
    waitDone(tag, WIDTH, 0);
    finishIdle(tag);
  endtask

  // Linear sequence of directed steps
  initial begin
    logic sawDone;
    rst     = 1'b1;
    start   = 1'b0;
    bin     = '0;
    lastExp = '0;
    tick();
    tick();
    checkOutput("reset outputs", {26'd0, busy, done, ovf, thou, hund, tens, ones}, 32'd0);
    rst = 1'b0;
    tick();

    runConv("zero", 0);
    runConv("v1234", 1234);
    runConv("v9999", 9999);
    runConv("v10000", 10000);
    runConv("v7", 7);

    // start pulsed mid-SHIFT is ignored, then back-to-back accept in DONE
    applyStimulus(4321);
    repeat (4) tick();
    start = 1'b1;
    bin   = WIDTH'(55);
    tick();
    start = 1'b0;
    waitDone("v4321", WIDTH - 5, 0);
    start = 1'b1;
    bin   = WIDTH'(55);
    sbq.push_back(expOf(55));
    tick();
    start = 1'b0;
    waitDone("b2b55", WIDTH, 0);
    finishIdle("b2b55");

    // reset in the middle of a conversion aborts it
    runConv("v8765", 8765);
    applyStimulus(42);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort outputs", {26'd0, busy, done, ovf, thou, hund, tens, ones}, 32'd0);
    rst     = 1'b0;
    sbq.delete();
    lastExp = '0;
    sawDone = 1'b0;
    repeat (20) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort no done", {31'd0, sawDone}, 32'd0);

    // sampled sweep of the input range with boundaries
    for (int v = 0; v < 20; v++) runConv("sweep", v);
    for (int v = 20; v < 16384; v += 331) runConv("sweep", v);
    runConv("v9998", 9998);
    runConv("v10001", 10001);
    runConv("v16383", 16383);
    runConv("v9990", 9990);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
